// File: rtl/ping_pong_ctrl_n_if.sv
// ---------------------------------------------------------------------------
// ping_pong_ctrl_n_if
// Handshake and bank-control bundle for the ping-pong buffer controller.
//
// Signals:
//   wr_valid / wr_ready             producer row handshake
//   rd_ready / rd_valid             consumer row handshake (rd_valid is 1 cycle
//                                   after the bank read is issued)
//   rd_bank, rd_last                consumer dout select and last-row flag
//   bank{0,1}_ena/_wea/_addra       buffer bank port controls
//   slicing_idx                     module slice written into the write bank
//   bank_full                       per-bank full flags
//   wr_stall_cnt                    only when PPB_CTRL_STALL_CNT_EN is defined
//
// Modports: master = controller side, slave = producer/consumer/bank side.
// ---------------------------------------------------------------------------
interface ping_pong_ctrl_n_if #(
  parameter int TOTAL_DEPTH   = 16,
  parameter int TOTAL_MODULES = 3
);
  localparam int ADDR_WIDTH = $clog2(TOTAL_DEPTH);
  localparam int SLICE_W    = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1;

  logic                  wr_valid;
  logic                  wr_ready;
  logic                  rd_ready;
  logic                  rd_valid;
  logic                  rd_bank;
  logic                  rd_last;
  logic                  bank0_ena;
  logic                  bank0_wea;
  logic [ADDR_WIDTH-1:0] bank0_addra;
  logic                  bank1_ena;
  logic                  bank1_wea;
  logic [ADDR_WIDTH-1:0] bank1_addra;
  logic [SLICE_W-1:0]    slicing_idx;
  logic [1:0]            bank_full;
`ifdef PPB_CTRL_STALL_CNT_EN
  logic [15:0]           wr_stall_cnt;
`endif

  modport master (
`ifdef PPB_CTRL_STALL_CNT_EN
    output wr_stall_cnt,
`endif
    input  wr_valid, rd_ready,
    output wr_ready, rd_valid, rd_bank, rd_last,
    output bank0_ena, bank0_wea, bank0_addra,
    output bank1_ena, bank1_wea, bank1_addra,
    output slicing_idx, bank_full
  );

  modport slave (
`ifdef PPB_CTRL_STALL_CNT_EN
    input  wr_stall_cnt,
`endif
    output wr_valid, rd_ready,
    input  wr_ready, rd_valid, rd_bank, rd_last,
    input  bank0_ena, bank0_wea, bank0_addra,
    input  bank1_ena, bank1_wea, bank1_addra,
    input  slicing_idx, bank_full
  );
endinterface

// File: rtl/ping_pong_ctrl_n.sv
// ---------------------------------------------------------------------------
// ping_pong_ctrl_n
// Ping-pong (double) buffer controller. A producer fills one bank row by row
// while the consumer drains the other; full flags hand banks between sides.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   clear   synchronous flush of all state
//   bus     ping_pong_ctrl_n_if.master (handshakes, bank controls, status)
//
// Optional build macro: PPB_CTRL_STALL_CNT_EN adds bus.wr_stall_cnt, a
// saturating 16-bit count of cycles where wr_valid is held off by wr_ready.
// ---------------------------------------------------------------------------
module ping_pong_ctrl_n #(
  parameter  int TOTAL_DEPTH   = 16,
  parameter  int TOTAL_MODULES = 3,
  localparam int ADDR_WIDTH    = $clog2(TOTAL_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  ping_pong_ctrl_n_if.master       bus
);
  localparam int                    SLICE_W    = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(TOTAL_DEPTH - 1);
  localparam logic [SLICE_W-1:0]    SLICE_LAST = SLICE_W'(TOTAL_MODULES - 1);

  logic                  wsel, wsel_nxt;
  logic                  rsel, rsel_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_nxt;
  logic [1:0]            full, full_nxt;
  logic [SLICE_W-1:0]    slice, slice_nxt;
  logic                  rd_vld_p1, rd_bank_p1, rd_last_p1;
  logic                  wr_ready;
  logic                  wr_fire, rd_fire;

  // Handshakes are gated by rst_n so no bank strobe leaks out during reset.
  // A write needs the write bank not full and a read needs the read bank
  // full, so both can never target the same bank in one cycle.
  assign wr_ready = ~full[wsel];
  assign wr_fire  = bus.wr_valid & wr_ready & rst_n;
  assign rd_fire  = bus.rd_ready & full[rsel] & rst_n;

  always_comb begin
    wsel_nxt    = wsel;
    rsel_nxt    = rsel;
    wr_addr_nxt = wr_addr;
    rd_addr_nxt = rd_addr;
    full_nxt    = full;
    slice_nxt   = slice;
    if (wr_fire) begin
      if (wr_addr == ADDR_LAST) begin
        full_nxt[wsel] = 1'b1;
        wr_addr_nxt    = '0;
        wsel_nxt       = ~wsel;
        slice_nxt      = (slice == SLICE_LAST) ? '0 : slice + SLICE_W'(1);
      end else begin
        wr_addr_nxt = wr_addr + ADDR_WIDTH'(1);
      end
    end
    // Touches only full[rsel]; a concurrent write completion updates the
    // other bit, so both completions land independently.
    if (rd_fire) begin
      if (rd_addr == ADDR_LAST) begin
        full_nxt[rsel] = 1'b0;
        rd_addr_nxt    = '0;
        rsel_nxt       = ~rsel;
      end else begin
        rd_addr_nxt = rd_addr + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsel    <= 1'b0;
      rsel    <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      full    <= 2'b00;
      slice   <= '0;
    end else if (clear) begin
      wsel    <= 1'b0;
      rsel    <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      full    <= 2'b00;
      slice   <= '0;
    end else begin
      wsel    <= wsel_nxt;
      rsel    <= rsel_nxt;
      wr_addr <= wr_addr_nxt;
      rd_addr <= rd_addr_nxt;
      full    <= full_nxt;
      slice   <= slice_nxt;
    end
  end

  // ---- stage p0 -> p1: bank read latency, consumer qualifiers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1  <= 1'b0;
      rd_bank_p1 <= 1'b0;
      rd_last_p1 <= 1'b0;
    end else if (clear) begin
      rd_vld_p1  <= 1'b0;
      rd_bank_p1 <= 1'b0;
      rd_last_p1 <= 1'b0;
    end else begin
      rd_vld_p1  <= rd_fire;
      rd_bank_p1 <= rd_fire ? rsel : rd_bank_p1;
      rd_last_p1 <= rd_fire & (rd_addr == ADDR_LAST);
    end
  end

  // A bank that is the non-full write bank is addressed by the write
  // pointer; otherwise it is (or will next be) the read bank.
  assign bus.bank0_ena   = (wr_fire & ~wsel) | (rd_fire & ~rsel);
  assign bus.bank0_wea   = wr_fire & ~wsel;
  assign bus.bank0_addra = (~wsel & ~full[0]) ? wr_addr : rd_addr;
  assign bus.bank1_ena   = (wr_fire & wsel) | (rd_fire & rsel);
  assign bus.bank1_wea   = wr_fire & wsel;
  assign bus.bank1_addra = (wsel & ~full[1]) ? wr_addr : rd_addr;

  assign bus.wr_ready    = wr_ready;
  assign bus.rd_valid    = rd_vld_p1;
  assign bus.rd_bank     = rd_bank_p1;
  assign bus.rd_last     = rd_last_p1;
  assign bus.slicing_idx = slice;
  assign bus.bank_full   = full;

`ifdef PPB_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clear) begin
      stall_cnt <= '0;
    end else if (bus.wr_valid && !wr_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.wr_stall_cnt = stall_cnt;
`else
  // Stall counter not built in this configuration.
`endif

endmodule

// File: tb/tb_ping_pong_ctrl_n.sv
// ---------------------------------------------------------------------------
// tb_ping_pong_ctrl_n
// Directed bench for ping_pong_ctrl_n with TOTAL_DEPTH=4, TOTAL_MODULES=3.
// Inputs change and outputs are sampled 1 time unit after the falling edge.
// ---------------------------------------------------------------------------
module tb_ping_pong_ctrl_n;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic clear = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  ping_pong_ctrl_n_if #(.TOTAL_DEPTH(4), .TOTAL_MODULES(3)) bus ();

  ping_pong_ctrl_n #(.TOTAL_DEPTH(4), .TOTAL_MODULES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_b0(input string tag, input logic ena, input logic wea, input int addr);
    chk({tag, " b0_ena"}, 32'(bus.bank0_ena), 32'(ena));
    chk({tag, " b0_wea"}, 32'(bus.bank0_wea), 32'(wea));
    if (ena) chk({tag, " b0_addra"}, 32'(bus.bank0_addra), 32'(addr));
  endtask

  task automatic chk_b1(input string tag, input logic ena, input logic wea, input int addr);
    chk({tag, " b1_ena"}, 32'(bus.bank1_ena), 32'(ena));
    chk({tag, " b1_wea"}, 32'(bus.bank1_wea), 32'(wea));
    if (ena) chk({tag, " b1_addra"}, 32'(bus.bank1_addra), 32'(addr));
  endtask

  task automatic chk_rd(input string tag, input logic vld, input logic bank, input logic last);
    chk({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(vld));
    chk({tag, " rd_bank"},  32'(bus.rd_bank),  32'(bank));
    chk({tag, " rd_last"},  32'(bus.rd_last),  32'(last));
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;

    // Reset asserted with a pending producer row: no strobes may escape.
    #2;
    rst_n = 1'b0;
    bus.wr_valid = 1'b1;
    #1;
    chk("rst bank_full", 32'(bus.bank_full), 32'd0);
    chk("rst slicing", 32'(bus.slicing_idx), 32'd0);
    chk("rst wr_ready", 32'(bus.wr_ready), 32'd1);
    chk_rd("rst", 1'b0, 1'b0, 1'b0);
    chk_b0("rst", 1'b0, 1'b0, 0);
    chk_b1("rst", 1'b0, 1'b0, 0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Fill bank0: addresses 0..3, slice 0.
    for (int i = 0; i < 4; i++) begin
      chk_b0("fill0", 1'b1, 1'b1, i);
      chk_b1("fill0", 1'b0, 1'b0, 0);
      chk("fill0 slicing", 32'(bus.slicing_idx), 32'd0);
      nxt();
    end
    chk("fill0 bank_full", 32'(bus.bank_full), 32'b01);
    chk("fill0 slicing next", 32'(bus.slicing_idx), 32'd1);
    chk("fill0 wr_ready", 32'(bus.wr_ready), 32'd1);

    // Fill bank1: addresses 0..3, slice 1; then both banks full.
    for (int i = 0; i < 4; i++) begin
      chk_b1("fill1", 1'b1, 1'b1, i);
      chk_b0("fill1", 1'b0, 1'b0, 0);
      chk("fill1 slicing", 32'(bus.slicing_idx), 32'd1);
      nxt();
    end
    chk("both full bank_full", 32'(bus.bank_full), 32'b11);
    chk("both full wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("both full slicing", 32'(bus.slicing_idx), 32'd2);
    chk_b0("9th write", 1'b0, 1'b0, 0);
    chk_b1("9th write", 1'b0, 1'b0, 0);
    nxt();
    chk("9th held bank_full", 32'(bus.bank_full), 32'b11);
    chk("9th held wr_ready", 32'(bus.wr_ready), 32'd0);

    // Drain bank0 with rd_ready held; rd_valid lags the read by one cycle.
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk_b0("drain0", 1'b1, 1'b0, i);
      chk_b1("drain0", 1'b0, 1'b0, 0);
      if (i == 0) chk("drain0 rd_valid first", 32'(bus.rd_valid), 32'd0);
      else        chk_rd("drain0", 1'b1, 1'b0, 1'b0);
      nxt();
    end
    chk_rd("drain0 last", 1'b1, 1'b0, 1'b1);
    chk("drain0 bank_full", 32'(bus.bank_full), 32'b10);

    // Concurrent: write bank0 (slice 2) while reading bank1.
    bus.wr_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk_b0("cc0", 1'b1, 1'b1, k);
      chk_b1("cc0", 1'b1, 1'b0, k);
      chk("cc0 slicing", 32'(bus.slicing_idx), 32'd2);
      if (k > 0) chk_rd("cc0", 1'b1, 1'b1, 1'b0);
      nxt();
    end
    // Both completions on the same edge; slice wraps to 0 on the fourth fill.
    chk("cc0 bank_full", 32'(bus.bank_full), 32'b01);
    chk("cc0 slicing wrap", 32'(bus.slicing_idx), 32'd0);
    chk_rd("cc0 last", 1'b1, 1'b1, 1'b1);

    // Concurrent: write bank1 while reading bank0.
    for (int k = 0; k < 4; k++) begin
      chk_b1("cc1", 1'b1, 1'b1, k);
      chk_b0("cc1", 1'b1, 1'b0, k);
      chk("cc1 slicing", 32'(bus.slicing_idx), 32'd0);
      if (k > 0) chk_rd("cc1", 1'b1, 1'b0, 1'b0);
      nxt();
    end
    chk("cc1 bank_full", 32'(bus.bank_full), 32'b10);
    chk("cc1 slicing", 32'(bus.slicing_idx), 32'd1);
    chk_rd("cc1 last", 1'b1, 1'b0, 1'b1);

    // Two writes into bank0 while reading bank1, then reset mid-transaction.
    for (int k = 0; k < 2; k++) begin
      chk_b0("part", 1'b1, 1'b1, k);
      chk_b1("part", 1'b1, 1'b0, k);
      nxt();
    end
    chk_rd("pre-rst", 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid rst bank_full", 32'(bus.bank_full), 32'd0);
    chk("mid rst slicing", 32'(bus.slicing_idx), 32'd0);
    chk_rd("mid rst", 1'b0, 1'b0, 1'b0);
    chk_b0("mid rst", 1'b0, 1'b0, 0);
    chk_b1("mid rst", 1'b0, 1'b0, 0);
    nxt();
    rst_n = 1'b1;
    #1;
    chk_b0("post rst", 1'b1, 1'b1, 0);
    chk_b1("post rst", 1'b0, 1'b0, 0);
    chk("post rst wr_ready", 32'(bus.wr_ready), 32'd1);
    nxt();

    // Synchronous clear overrides the handshake in its cycle.
    chk_b0("pre clear", 1'b1, 1'b1, 1);
    clear = 1'b1;
    nxt();
    clear = 1'b0;
    #1;
    chk_b0("post clear", 1'b1, 1'b1, 0);
    chk("post clear bank_full", 32'(bus.bank_full), 32'd0);
    chk_rd("post clear", 1'b0, 1'b0, 1'b0);

    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    nxt();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
